traffic_phase_seq: RTL
======================

# traffic_phase_seq

Phase sequencer that drives the `traffic` light decoder. It generates the enable `i` and the 3-bit phase select `s0`/`s1`/`s2` on a timed schedule: green then yellow for each of four approaches, round-robin. Approaches with no pending demand are skipped. It replaces the free-running stimulus currently used to exercise the decoder and sits directly between the system clock domain and the decoder inputs.

## Interface
Parameters:
- `TICK_DIV`, default 1000: clk cycles per timing tick; legal range is 1 or more.
- `GREEN_TICKS`, default 30: ticks per green phase; legal range is 1 or more.
- `YELLOW_TICKS`, default 4: ticks per yellow phase; legal range is 1 or more.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  run enable; low freezes the sequencer and blanks the decoder.
- `req`  in  4  per-approach demand; `req[n]` set means approach n wants green. Level input, sampled only at decision points.
- `i`  out  1  decoder enable.
- `s0`  out  1  phase code MSB.
- `s1`  out  1  phase code middle bit.
- `s2`  out  1  phase code LSB.
- `phase_start`  out  1  one-cycle pulse on the first cycle of each new phase.

## Operation
- Phase code P = {s0,s1,s2}, range 0..7:
  - P = 2n: approach n green.
  - P = 2n+1: approach n yellow.
- State machine, all states registered:
  - IDLE (reset, or `en` low) -> GREEN(n) -> YELLOW(n) -> GREEN(next) -> ...
- Tick prescaler:
  - Counts 0..TICK_DIV-1 while running.
  - `tick` is asserted in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
- Phase timer:
  - Counts ticks and is cleared on every phase entry.
  - GREEN exits when the timer reaches GREEN_TICKS.
  - YELLOW exits when the timer reaches YELLOW_TICKS.
- Next-approach select (evaluated at YELLOW(n) exit):
  - Search `req` starting at approach (n+1) mod 4, wrapping round.
  - Choose the first approach with `req` set.
  - If `req` is all zero, choose (n+1) mod 4 (fixed cycle).
  - `req[n]` alone selects n again, but only after all other approaches have been checked.
- Reset:
  - `rst` high forces `i`=0, P=0, `phase_start`=0, prescaler=0, timer=0, state=IDLE.
  - Reset asserted mid-phase aborts immediately. There is no yellow completion.
- IDLE exit:
  - Occurs on the first edge with `rst`=0 and `en`=1.
  - Enters GREEN(0) regardless of `req`.
- `en` deasserted mid-phase:
  - Returns to IDLE next edge: `i`=0, P=0, counters cleared.
  - A re-enable always restarts at GREEN(0). There is no resume.
- Widths:
  - Prescaler width is $clog2(TICK_DIV).
  - Timer width is $clog2(max(GREEN_TICKS, YELLOW_TICKS)+1).
  - No overflow is possible within the legal parameter range.

## Timing
- All outputs are registered and there is no combinational input-to-output path.
- From IDLE: at the edge where `en`=1 and `rst`=0 are sampled, `i` goes 1, P goes 0 and `phase_start` goes 1, all visible after that edge.
- Phase length:
  - GREEN lasts exactly GREEN_TICKS × TICK_DIV cycles.
  - YELLOW lasts exactly YELLOW_TICKS × TICK_DIV cycles.
- `phase_start` is high for exactly one cycle per phase entry, coincident with the first cycle of the new P.
- `req` is sampled in the last cycle of YELLOW. A change in any other cycle has no effect on sequencing.
- The IDLE-exit condition and a `req` change in the same cycle do not interact: GREEN(0) wins.
- `rst` has priority over `en`.

## Structure
- Shared package `traffic_pkg`:
  - Phase-code constants PH_G0..PH_Y3 (values 0..7).
  - State enum IDLE/GREEN/YELLOW.
  - Approach count NUM_APPROACH=4.
- Sub-module `tick_prescaler`:
  - Parameter TICK_DIV.
  - Ports `clk`, `rst`, `clr`, `tick`.
  - `clr` is asserted on phase entry and IDLE so that every phase starts tick-aligned.
- Next-approach priority search is a small combinational function inside the top module.

## Test plan
All scenarios use TICK_DIV=4, GREEN_TICKS=5, YELLOW_TICKS=2, so green is 20 cycles and yellow is 8 cycles.
- Reset, then `en`=1 and `req`=4'b1111 -> P sequence 0,1,2,3,4,5,6,7,0 with per-phase durations 20,8,20,8,...; `i`=1 throughout; 9 `phase_start` pulses.
- `req`=4'b0100 held -> after phase 1, P = 4; each following yellow 5 is followed by 4 again. Approaches 1 and 3 are never green.
- `req`=4'b0000 -> plain round-robin 0..7, identical to the first scenario.
- `rst` pulsed at cycle 10 of phase 3 -> next cycle `i`=0 and P=0; P=0 with `phase_start` then follows on the first edge after `rst` low with `en`=1.
- `en` low at cycle 5 of phase 2 for 7 cycles -> `i`=0 during the gap; after re-enable, P=0 and lasts a full 20 cycles.
- `req` toggles only during green -> no effect on sequencing; only the value present in the last yellow cycle selects the next approach.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase sequencer: phase codes,
// sequencer state encoding and approach count.
package traffic_pkg;

  localparam int NUM_APPROACH = 4;

  // Phase code P = {s0,s1,s2}: even = approach green, odd = approach yellow.
  localparam logic [2:0] PH_G0 = 3'd0;
  localparam logic [2:0] PH_Y0 = 3'd1;
  localparam logic [2:0] PH_G1 = 3'd2;
  localparam logic [2:0] PH_Y1 = 3'd3;
  localparam logic [2:0] PH_G2 = 3'd4;
  localparam logic [2:0] PH_Y2 = 3'd5;
  localparam logic [2:0] PH_G3 = 3'd6;
  localparam logic [2:0] PH_Y3 = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_t;

  // Builds the phase code for an approach and colour.
  function automatic logic [2:0] phase_code(input logic [1:0] appr, input logic yellow);
    return {appr, yellow};
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles. clr restarts
// the count so that each phase begins on a tick boundary.
module tick_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == LAST);

  // Count 0..TICK_DIV-1 and wrap; held at zero while cleared.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_phase_seq.sv
// Timed green/yellow phase sequencer for four approaches with demand-based
// skipping. Outputs are decoded from registers only.
// Handshake note: there is no valid/ready handshake here; req is a level
// input sampled only on the last cycle of a yellow phase.
module traffic_phase_seq
  import traffic_pkg::*;
#(
  parameter int TICK_DIV     = 1000,
  parameter int GREEN_TICKS  = 30,
  parameter int YELLOW_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic       i,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       phase_start,
  output logic [1:0] dbg_state
);

  localparam int TMAX = (GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] G_LAST = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] Y_LAST = TW'(YELLOW_TICKS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_appr;
  logic [1:0]    w_appr_nxt;
  logic [TW-1:0] r_timer;
  logic          r_phase_start;
  logic          w_enter;
  logic          w_tick;
  logic          w_clr;
  logic          w_timer_done;
  logic [2:0]    w_p;

  // Round-robin search from the approach after cur; all-zero demand falls
  // back to the next approach, and cur itself is checked last.
  function automatic logic [1:0] next_appr(input logic [1:0] cur, input logic [3:0] dem);
    logic [1:0] idx;
    logic       found;
    next_appr = cur + 2'd1;
    found     = 1'b0;
    for (int k = 1; k <= NUM_APPROACH; k++) begin
      idx = cur + k[1:0];
      if (!found && dem[idx]) begin
        next_appr = idx;
        found     = 1'b1;
      end
    end
  endfunction

  assign w_clr = w_enter || (w_state_nxt == IDLE);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .tick(w_tick)
  );

  // Timer reaches its limit in the last cycle of the phase, on the final tick.
  always_comb begin
    w_timer_done = 1'b0;
    if (w_tick) begin
      w_timer_done = (r_timer == ((r_state == GREEN) ? G_LAST : Y_LAST));
    end
  end

  // Phase timer: counts ticks, cleared on every phase entry and in IDLE.
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_timer <= '0;
    end else if (w_tick) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // State register: state, current approach and phase-entry pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_appr        <= 2'd0;
      r_phase_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_appr        <= w_appr_nxt;
      r_phase_start <= w_enter;
    end
  end

  // Next-state logic; en low always drops back to IDLE with approach 0.
  always_comb begin
    w_state_nxt = r_state;
    w_appr_nxt  = r_appr;
    w_enter     = 1'b0;
    case (r_state)
      IDLE: begin
        w_appr_nxt = 2'd0;
        if (en) begin
          w_state_nxt = GREEN;
          w_enter     = 1'b1;
        end
      end
      GREEN: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_appr_nxt  = 2'd0;
        end else if (w_timer_done) begin
          w_state_nxt = YELLOW;
          w_enter     = 1'b1;
        end
      end
      YELLOW: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_appr_nxt  = 2'd0;
        end else if (w_timer_done) begin
          w_state_nxt = GREEN;
          w_appr_nxt  = next_appr(r_appr, req);
          w_enter     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_appr_nxt  = 2'd0;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    w_p = (r_state == IDLE) ? PH_G0 : phase_code(r_appr, r_state == YELLOW);
  end

  assign i           = (r_state != IDLE);
  assign s0          = w_p[2];
  assign s1          = w_p[1];
  assign s2          = w_p[0];
  assign phase_start = r_phase_start;
  assign dbg_state   = r_state;

endmodule
